// File: rtl/dm_cache_ctrl.sv
// Controller for a 1024-line direct-mapped write-back cache with 128-bit lines.
// It handles hit/miss, victim write-back and line fill against single-port tag/data arrays.
module dm_cache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_valid_i,
  input  logic         cpu_req_rw_i,
  input  logic [31:0]  cpu_req_addr_i,
  input  logic [31:0]  cpu_req_data_i,
  output logic         cpu_res_ready_o,
  output logic [31:0]  cpu_res_data_o,
  output logic         mem_req_valid_o,
  output logic         mem_req_rw_o,
  output logic [31:0]  mem_req_addr_o,
  output logic [127:0] mem_req_data_o,
  input  logic         mem_data_ready_i,
  input  logic [127:0] mem_data_i,
  output logic [10:0]  tag_req_o,
  output logic [19:0]  tag_write_o,
  input  logic [19:0]  tag_read_i,
  output logic [10:0]  data_req_o,
  output logic [127:0] data_write_o,
  input  logic [127:0] data_read_i
);

  typedef enum logic [1:0] {StIdle, StCompare, StWriteBack, StAllocate} state_e;

  state_e         state_q, state_d;
  logic           req_rw_q;
  logic [31:2]    req_addr_q;
  logic [31:0]    req_data_q;
  logic [17:0]    victim_tag_q;
  logic [127:0]   victim_line_q;
  logic [31:0]    res_data_q, res_data_d;

  logic [17:0]    req_tag;
  logic [9:0]     req_index;
  logic [1:0]     req_word;
  logic           hit;
  logic           accept;
  logic           cap_victim;
  logic           tag_we, data_we;
  logic [9:0]     arr_index;
  logic [31:0]    read_word;
  logic [127:0]   merged_line;
  logic           unused_addr_bits;

  // Byte offset is ignored: all accesses are whole words.
  assign unused_addr_bits = ^cpu_req_addr_i[1:0];

  assign req_tag   = req_addr_q[31:14];
  assign req_index = req_addr_q[13:4];
  assign req_word  = req_addr_q[3:2];
  assign hit       = tag_read_i[19] && (tag_read_i[17:0] == req_tag);
  assign accept    = (state_q == StIdle) && cpu_req_valid_i;
  assign read_word = data_read_i[{req_word, 5'b0} +: 32];

  always_comb begin
    merged_line = data_read_i;
    merged_line[{req_word, 5'b0} +: 32] = req_data_q;
  end

  always_comb begin
    state_d         = state_q;
    res_data_d      = res_data_q;
    cpu_res_ready_o = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_rw_o    = 1'b0;
    mem_req_addr_o  = 32'h0;
    mem_req_data_o  = 128'h0;
    tag_we          = 1'b0;
    data_we         = 1'b0;
    tag_write_o     = 20'h0;
    data_write_o    = 128'h0;
    cap_victim      = 1'b0;
    arr_index       = (state_q == StIdle) ? 10'd0 : req_index;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_valid_i) state_d = StCompare;
      end
      StCompare: begin
        if (hit) begin
          cpu_res_ready_o = 1'b1;
          state_d         = StIdle;
          if (req_rw_q) begin
            data_we      = 1'b1;
            data_write_o = merged_line;
            tag_we       = 1'b1;
            tag_write_o  = {2'b11, req_tag};
          end else begin
            res_data_d = read_word;
          end
        end else begin
          cap_victim = 1'b1;
          state_d    = (tag_read_i[19] && tag_read_i[18]) ? StWriteBack : StAllocate;
        end
      end
      StWriteBack: begin
        mem_req_valid_o = 1'b1;
        mem_req_rw_o    = 1'b1;
        mem_req_addr_o  = {victim_tag_q, req_index, 4'h0};
        mem_req_data_o  = victim_line_q;
        if (mem_data_ready_i) state_d = StAllocate;
      end
      StAllocate: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {req_tag, req_index, 4'h0};
        if (mem_data_ready_i) begin
          data_we      = 1'b1;
          data_write_o = mem_data_i;
          tag_we       = 1'b1;
          tag_write_o  = {2'b10, req_tag};
          // Return to compare: the refilled line now hits, and writes mark it dirty there.
          state_d      = StCompare;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_res_data_o = res_data_d;
  // A reset landing mid-transaction must not disturb the arrays.
  assign tag_req_o      = {arr_index, tag_we && !rst_i};
  assign data_req_o     = {arr_index, data_we && !rst_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      req_rw_q      <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= 32'h0;
      victim_tag_q  <= 18'h0;
      victim_line_q <= 128'h0;
      res_data_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      if (accept) begin
        req_rw_q   <= cpu_req_rw_i;
        req_addr_q <= cpu_req_addr_i[31:2];
        req_data_q <= cpu_req_data_i;
      end
      if (cap_victim) begin
        victim_tag_q  <= tag_read_i[17:0];
        victim_line_q <= data_read_i;
      end
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with behavioural tag/data arrays.
// Memory-side handshakes are driven by hand.
module tb_dm_cache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_valid_i, cpu_req_rw_i;
  logic [31:0]  cpu_req_addr_i, cpu_req_data_i;
  logic         cpu_res_ready_o;
  logic [31:0]  cpu_res_data_o;
  logic         mem_req_valid_o, mem_req_rw_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_req_data_o;
  logic         mem_data_ready_i;
  logic [127:0] mem_data_i;
  logic [10:0]  tag_req_o, data_req_o;
  logic [19:0]  tag_write_o, tag_read_i;
  logic [127:0] data_write_o, data_read_i;

  logic [19:0]  tag_mem  [1024];
  logic [127:0] data_mem [1024];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] Line1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LineD = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
  localparam logic [127:0] Line2 = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

  always #5 clk_i = ~clk_i;

  dm_cache_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cpu_req_valid_i  (cpu_req_valid_i),
    .cpu_req_rw_i     (cpu_req_rw_i),
    .cpu_req_addr_i   (cpu_req_addr_i),
    .cpu_req_data_i   (cpu_req_data_i),
    .cpu_res_ready_o  (cpu_res_ready_o),
    .cpu_res_data_o   (cpu_res_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_rw_o     (mem_req_rw_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_data_ready_i (mem_data_ready_i),
    .mem_data_i       (mem_data_i),
    .tag_req_o        (tag_req_o),
    .tag_write_o      (tag_write_o),
    .tag_read_i       (tag_read_i),
    .data_req_o       (data_req_o),
    .data_write_o     (data_write_o),
    .data_read_i      (data_read_i)
  );

  assign tag_read_i  = tag_mem[tag_req_o[10:1]];
  assign data_read_i = data_mem[data_req_o[10:1]];

  always @(posedge clk_i) begin
    if (tag_req_o[0])  tag_mem[tag_req_o[10:1]]   <= tag_write_o;
    if (data_req_o[0]) data_mem[data_req_o[10:1]] <= data_write_o;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cpu_req(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    cpu_req_valid_i = 1'b1;
    cpu_req_rw_i    = rw;
    cpu_req_addr_i  = addr;
    cpu_req_data_i  = data;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      tag_mem[i]  = 20'h0;
      data_mem[i] = 128'h0;
    end
    rst_i = 1'b1;
    cpu_req_valid_i = 1'b0; cpu_req_rw_i = 1'b0;
    cpu_req_addr_i = 32'h0; cpu_req_data_i = 32'h0;
    mem_data_ready_i = 1'b0; mem_data_i = 128'h0;
    step(); step();
    rst_i = 1'b0;

    // Reset state
    chk("rst_ready", cpu_res_ready_o, 0);
    chk("rst_rdata", cpu_res_data_o, 0);
    chk("rst_mvalid", mem_req_valid_o, 0);
    chk("rst_maddr", mem_req_addr_o, 0);
    chk("rst_mdata", mem_req_data_o, 0);
    chk("rst_tagreq", tag_req_o, 0);
    chk("rst_datareq", data_req_o, 0);

    // 1: cold read miss, fill after 3 cycles
    cpu_req(1'b0, 32'h0000_0040, 32'h0);
    step();
    chk("t1_cmp_ready", cpu_res_ready_o, 0);
    chk("t1_cmp_tagreq", tag_req_o, 11'h008);
    step();
    chk("t1_fill_valid", mem_req_valid_o, 1);
    chk("t1_fill_rw", mem_req_rw_o, 0);
    chk("t1_fill_addr", mem_req_addr_o, 32'h40);
    step();
    chk("t1_fill_hold", mem_req_valid_o, 1);
    step();
    mem_data_ready_i = 1'b1; mem_data_i = Line1;
    step();
    mem_data_ready_i = 1'b0; mem_data_i = 128'h0;
    chk("t1_tag", tag_mem[4], 20'h80000);
    chk("t1_line", data_mem[4], Line1);
    chk("t1_mvalid_drop", mem_req_valid_o, 0);
    chk("t1_ready", cpu_res_ready_o, 1);
    chk("t1_rdata", cpu_res_data_o, 32'h11111111);
    cpu_req_valid_i = 1'b0;
    step();
    chk("t1_idle_ready", cpu_res_ready_o, 0);
    chk("t1_rdata_hold", cpu_res_data_o, 32'h11111111);

    // 2: read hit, one cycle after accept
    cpu_req(1'b0, 32'h0000_0044, 32'h0);
    step();
    chk("t2_ready", cpu_res_ready_o, 1);
    chk("t2_rdata", cpu_res_data_o, 32'h22222222);
    chk("t2_no_mem", mem_req_valid_o, 0);
    cpu_req_valid_i = 1'b0;
    step();
    chk("t2_pulse", cpu_res_ready_o, 0);

    // 3: write hit marks line dirty
    cpu_req(1'b1, 32'h0000_0048, 32'hDEADBEEF);
    step();
    chk("t3_ready", cpu_res_ready_o, 1);
    chk("t3_tag_we", tag_req_o, 11'h009);
    chk("t3_tag_wr", tag_write_o, 20'hC0000);
    chk("t3_data_we", data_req_o, 11'h009);
    cpu_req_valid_i = 1'b0;
    step();
    chk("t3_tag", tag_mem[4], 20'hC0000);
    chk("t3_line", data_mem[4], LineD);
    chk("t3_rdata_hold", cpu_res_data_o, 32'h22222222);

    // 4: conflict miss on dirty line: write-back then fill
    cpu_req(1'b0, 32'h0000_4040, 32'h0);
    step();
    chk("t4_cmp_ready", cpu_res_ready_o, 0);
    step();
    chk("t4_wb_valid", mem_req_valid_o, 1);
    chk("t4_wb_rw", mem_req_rw_o, 1);
    chk("t4_wb_addr", mem_req_addr_o, 32'h40);
    chk("t4_wb_data", mem_req_data_o, LineD);
    mem_data_ready_i = 1'b1;
    step();
    mem_data_ready_i = 1'b0;
    chk("t4_fill_valid", mem_req_valid_o, 1);
    chk("t4_fill_rw", mem_req_rw_o, 0);
    chk("t4_fill_addr", mem_req_addr_o, 32'h4040);
    chk("t4_line_kept", data_mem[4], LineD);
    step();
    chk("t4_fill_hold", mem_req_addr_o, 32'h4040);
    mem_data_ready_i = 1'b1; mem_data_i = Line2;
    step();
    mem_data_ready_i = 1'b0; mem_data_i = 128'h0;
    chk("t4_tag", tag_mem[4], 20'h80001);
    chk("t4_ready", cpu_res_ready_o, 1);
    chk("t4_rdata", cpu_res_data_o, 32'h0000000A);
    cpu_req_valid_i = 1'b0;
    step();

    // 5: back-to-back hits with valid held high
    cpu_req(1'b0, 32'h0000_4044, 32'h0);
    step();
    chk("t5_r1_ready", cpu_res_ready_o, 1);
    chk("t5_r1_data", cpu_res_data_o, 32'h0000000B);
    cpu_req_addr_i = 32'h0000_4048;
    step();
    chk("t5_gap", cpu_res_ready_o, 0);
    step();
    chk("t5_r2_ready", cpu_res_ready_o, 1);
    chk("t5_r2_data", cpu_res_data_o, 32'h0000000C);
    cpu_req_valid_i = 1'b0;
    step();
    step();
    chk("t5_no_dup", cpu_res_ready_o, 0);
    chk("t5_hold", cpu_res_data_o, 32'h0000000C);

    // 6: reset during fill wait
    cpu_req(1'b0, 32'h0000_8040, 32'h0);
    step();
    step();
    chk("t6_fill_valid", mem_req_valid_o, 1);
    chk("t6_fill_addr", mem_req_addr_o, 32'h8040);
    rst_i = 1'b1;
    mem_data_ready_i = 1'b1; mem_data_i = Line1;
    #1;
    chk("t6_no_tag_we", tag_req_o[0], 0);
    chk("t6_no_data_we", data_req_o[0], 0);
    step();
    rst_i = 1'b0; cpu_req_valid_i = 1'b0;
    mem_data_ready_i = 1'b0; mem_data_i = 128'h0;
    chk("t6_mvalid", mem_req_valid_o, 0);
    chk("t6_ready", cpu_res_ready_o, 0);
    chk("t6_rdata", cpu_res_data_o, 0);
    chk("t6_tag", tag_mem[4], 20'h80001);
    chk("t6_line", data_mem[4], Line2);
    step();
    chk("t6_idle", mem_req_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
